// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply exponentiation in the Montgomery domain,
// driving an external Montgomery multiplier through the mm_* master ports.
module montgomery_exp (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [511:0] in_x,
  input  logic [511:0] in_r,
  input  logic [511:0] in_e,
  input  logic [9:0]   e_len,
  input  logic [511:0] in_m,
  output logic [511:0] result,
  output logic         done,
  output logic         busy,
  output logic         mm_start,
  output logic [511:0] mm_a,
  output logic [511:0] mm_b,
  output logic [511:0] mm_m,
  input  logic [511:0] mm_result,
  input  logic         mm_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SQ_ISSUE  = 3'd1,
    SQ_WAIT   = 3'd2,
    MUL_ISSUE = 3'd3,
    MUL_WAIT  = 3'd4,
    NEXT      = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t       state_q, state_d;
  logic [511:0] x_q, x_d;
  logic [511:0] e_q, e_d;
  logic [511:0] m_q, m_d;
  logic [511:0] a_q, a_d;
  logic [8:0]   i_q, i_d;
  logic [511:0] result_q, result_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         mm_start_q, mm_start_d;
  logic [511:0] mm_a_q, mm_a_d;
  logic [511:0] mm_b_q, mm_b_d;
  logic [9:0]   len_eff_s;

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = m_q;

  // Exponent lengths beyond the operand width saturate to the full 512 bits.
  assign len_eff_s = (e_len > 10'd512) ? 10'd512 : e_len;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    e_d        = e_q;
    m_d        = m_q;
    a_d        = a_q;
    i_d        = i_q;
    result_d   = result_q;
    done_d     = 1'b0;
    busy_d     = 1'b0;
    mm_start_d = 1'b0;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d = in_x;
          e_d = in_e;
          m_d = in_m;
          a_d = in_r;
          if (len_eff_s == 10'd0) begin
            i_d     = 9'd0;
            state_d = DONE;
          end else begin
            i_d     = len_eff_s[8:0] - 9'd1;
            state_d = SQ_ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SQ_ISSUE:  state_d = SQ_WAIT;
      SQ_WAIT: begin
        if (mm_done) begin
          a_d     = mm_result;
          state_d = e_q[i_q] ? MUL_ISSUE : NEXT;
        end else begin
          state_d = SQ_WAIT;
        end
      end
      MUL_ISSUE: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mm_done) begin
          a_d     = mm_result;
          state_d = NEXT;
        end else begin
          state_d = MUL_WAIT;
        end
      end
      NEXT: begin
        if (i_q == 9'd0) begin
          state_d = DONE;
        end else begin
          i_d     = i_q - 9'd1;
          state_d = SQ_ISSUE;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Operands are registered on entry to an issue state and held through the wait.
    if (state_d == SQ_ISSUE) begin
      mm_start_d = 1'b1;
      mm_a_d     = a_d;
      mm_b_d     = a_d;
    end else if (state_d == MUL_ISSUE) begin
      mm_start_d = 1'b1;
      mm_a_d     = a_d;
      mm_b_d     = x_d;
    end else begin
      mm_start_d = 1'b0;
    end

    if (state_d == DONE) begin
      done_d   = 1'b1;
      result_d = a_d;
    end else begin
      done_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      x_q        <= 512'd0;
      e_q        <= 512'd0;
      m_q        <= 512'd0;
      a_q        <= 512'd0;
      i_q        <= 9'd0;
      result_q   <= 512'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
      mm_a_q     <= 512'd0;
      mm_b_q     <= 512'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      e_q        <= e_d;
      m_q        <= m_d;
      a_q        <= a_d;
      i_q        <= i_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
    end
  end

endmodule

// File: tb/tb_montgomery_exp.sv
// Scoreboard bench for montgomery_exp with a behavioural radix-2 Montgomery
// multiplier (fixed latency) answering on the mm_* ports.
module tb_montgomery_exp;

  localparam int MM_LAT = 3;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [511:0] in_x = 512'd0, in_r = 512'd0, in_e = 512'd0, in_m = 512'd0;
  logic [9:0]   e_len = 10'd0;
  logic [511:0] result;
  logic         done, busy, mm_start;
  logic [511:0] mm_a, mm_b, mm_m;
  logic [511:0] mm_result;
  logic         mm_done;

  montgomery_exp dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_r(in_r), .in_e(in_e), .e_len(e_len), .in_m(in_m),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mont_mul(input logic [511:0] a, input logic [511:0] b,
                                            input logic [511:0] m);
    logic [513:0] t;
    t = 514'd0;
    for (int j = 0; j < 512; j++) begin
      if (a[j]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[511:0];
  endfunction

  // Right-to-left binary exponentiation as an independent reference.
  function automatic logic [511:0] mont_pow(input logic [511:0] x, input logic [511:0] e,
                                            input int len, input logic [511:0] r,
                                            input logic [511:0] m);
    logic [511:0] acc, base;
    acc  = r;
    base = x;
    for (int j = 0; j < len; j++) begin
      if (e[j]) acc = mont_mul(acc, base, m);
      base = mont_mul(base, base, m);
    end
    return acc;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int j = 0; j < 16; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    logic [511:0] res;
    int           lat;
    int           k;
  } exp_t;

  exp_t         sb_q[$];
  logic [7:0]   op_q[$];
  logic [511:0] cur_x, cur_m;

  // Behavioural multiplier: mm_done is high at the L-th edge after mm_start is sampled.
  logic [511:0] cap_a, cap_b, cap_m;
  logic         mm_pending;
  int           mm_cnt;
  initial begin
    mm_done    = 1'b0;
    mm_result  = 512'd0;
    mm_pending = 1'b0;
    mm_cnt     = 0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (mm_pending) begin
        mm_cnt--;
        if (mm_cnt == 0) begin
          mm_pending = 1'b0;
          mm_done    = 1'b1;
          mm_result  = mont_mul(cap_a, cap_b, cap_m);
          if (busy) begin
            check_eq("mm_a_stable", mm_a, cap_a);
            check_eq("mm_b_stable", mm_b, cap_b);
            check_eq("mm_m_stable", mm_m, cap_m);
          end
        end
      end
      if (mm_start) begin
        logic [7:0] kind, obs;
        check_eq("ops_pending", op_q.size() > 0, 1'b1);
        if (op_q.size() > 0) begin
          kind = op_q.pop_front();
          obs  = (mm_a == mm_b) ? 8'h73 : 8'h6d;
          check_eq("op_kind", obs, kind);
          if (kind == 8'h6d) check_eq("mul_operand_x", mm_b, cur_x);
        end
        check_eq("mm_m_value", mm_m, cur_m);
        cap_a      = mm_a;
        cap_b      = mm_b;
        cap_m      = mm_m;
        mm_cnt     = MM_LAT;
        mm_pending = 1'b1;
      end
    end
  end

  // Output monitor: pops the scoreboard on done and polices done/busy shape.
  logic prev_done = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (prev_done) begin
        check_eq("done_pulse_width", done, 1'b0);
        check_eq("busy_after_done", busy, 1'b0);
      end else if (sb_q.size() > 0 && cyc >= sb_q[0].k) begin
        check_eq("busy_while_running", busy, 1'b1);
      end
      if (done) begin
        exp_t e;
        check_eq("done_expected", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("result", result, e.res);
          check_eq("latency", cyc + 1 - e.k, e.lat);
          check_eq("ops_left", op_q.size(), 0);
        end
      end
      prev_done = done;
    end
  end

  task automatic start_op(input logic [511:0] x, input logic [511:0] e, input logic [9:0] len,
                          input logic [511:0] m);
    exp_t          s;
    int            eff;
    logic [511:0]  r;
    r   = ~m + 512'd1;
    eff = (len > 10'd512) ? 512 : int'(len);
    s.lat = 1;
    for (int j = eff - 1; j >= 0; j--) begin
      op_q.push_back(8'h73);
      if (e[j]) op_q.push_back(8'h6d);
      s.lat += (MM_LAT + 1) * (1 + int'(e[j])) + 1;
    end
    s.res = mont_pow(x, e, eff, r, m);
    cur_x = x;
    cur_m = m;
    @(negedge clk);
    s.k = cyc + 1;
    sb_q.push_back(s);
    in_x  = x;
    in_r  = r;
    in_e  = e;
    e_len = len;
    in_m  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb_q.size() > 0 && t < 10000) begin
      @(negedge clk);
      t++;
    end
    check_eq("done_timeout", sb_q.size(), 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [511:0] rand_mod();
    logic [511:0] m;
    m = rand512();
    m[511] = 1'b1;
    m[0]   = 1'b1;
    return m;
  endfunction

  function automatic logic [511:0] rand_base();
    logic [511:0] x;
    x = rand512();
    x[511] = 1'b0;
    return x;
  endfunction

  logic [511:0] m1, x1, x2;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_mm_start", mm_start, 1'b0);
    check_eq("rst_result", result, 512'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    m1 = rand_mod();
    x1 = rand_base();
    x2 = rand_base();

    // Zero-length exponent: immediate done with the Montgomery one.
    start_op(x1, rand512(), 10'd0, m1);
    wait_idle();
    check_eq("elen0_result_is_r", result, ~m1 + 512'd1);

    start_op(x1, 512'd1, 10'd1, m1);
    wait_idle();
    check_eq("e1_result_is_x", result, x1);

    start_op(x1, 512'd5, 10'd3, m1);
    wait_idle();

    // Start while busy must not disturb the running exponentiation.
    start_op(x1, 512'd5, 10'd3, m1);
    repeat (4) @(negedge clk);
    in_x  = x2;
    in_e  = 512'd3;
    e_len = 10'd2;
    in_m  = rand_mod();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset during MUL_WAIT of the first multiply.
    start_op(x2, 512'd5, 10'd3, m1);
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_mm_start", mm_start, 1'b0);
    check_eq("abort_result", result, 512'd0);
    sb_q.delete();
    op_q.delete();
    #1;
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("post_abort_busy", busy, 1'b0);
    check_eq("post_abort_done", done, 1'b0);
    start_op(x1, 512'd1, 10'd1, m1);
    wait_idle();
    check_eq("rerun_result_is_x", result, x1);

    start_op(x2, rand512() & 512'hffff, 10'd16, m1);
    wait_idle();

    // Oversized e_len saturates to 512 bits.
    start_op(x2, ~512'd0, 10'd600, rand_mod());
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
